// File: rtl/game_text_render.sv
`timescale 1ns/1ps
// game_text_render
// Overlays a 16x4 character text box (8x16 px glyphs) onto a VGA pixel stream.
// Stage 0 turns the beam position into a text-ROM index, the text ROM answers
// one clock later with a character code, the font ROM answers one clock after
// that with a glyph row, and the composited colour is registered at T+4.
// All VGA timing and count signals travel through a matching 4-deep delay line.
// The highlighted-row selection is sampled only at the start of a frame, so a
// frame is always drawn with a single, consistent highlight.

module game_text_render #(
  parameter logic [10:0] XPOS   = 11'd400,
  parameter logic [10:0] YPOS   = 11'd300,
  parameter logic [11:0] FG_RGB = 12'hFFF,
  parameter logic [11:0] BG_RGB = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] vcount_in,
  input  logic [10:0] hcount_in,
  input  logic        vsync_in,
  input  logic        hsync_in,
  input  logic        vblnk_in,
  input  logic        hblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [1:0]  sel_row,
  input  logic        sel_en,
  output logic [7:0]  char_xy,
  input  logic [6:0]  char_code,
  output logic [10:0] font_addr,
  input  logic [7:0]  char_pixels,
  output logic [10:0] vcount_out,
  output logic [10:0] hcount_out,
  output logic        vsync_out,
  output logic        hsync_out,
  output logic        vblnk_out,
  output logic        hblnk_out,
  output logic [11:0] rgb_out
);

  // Box geometry in pixels; compared at 12 bits so XPOS+128 / YPOS+64 never wrap.
  localparam logic [11:0] BOX_W = 12'd128;
  localparam logic [11:0] BOX_H = 12'd64;
  localparam int          DEPTH = 4;

  // One beam sample: everything that is passed through with a fixed delay.
  typedef struct packed {
    logic [10:0] vcount;
    logic [10:0] hcount;
    logic        vsync;
    logic        hsync;
    logic        vblnk;
    logic        hblnk;
    logic [11:0] rgb;
  } beam_t;

  localparam beam_t BEAM_ZERO = beam_t'({$bits(beam_t){1'b0}});

  // Stage-0 (combinational) signals
  beam_t       beam_in;
  logic [10:0] rx;
  logic [10:0] ry;
  logic [11:0] h_ext;
  logic [11:0] v_ext;
  logic [11:0] xpos_ext;
  logic [11:0] ypos_ext;
  logic        in_box;
  logic        hl;
  logic        frame_start;
  logic [7:0]  char_xy_next;

  // Frame-latched highlight selection
  logic [1:0]  sel_row_lat;
  logic        sel_en_lat;

  // Delay line for the beam sample; beam_d[0] is T+1, beam_d[3] is T+4
  beam_t       beam_d [DEPTH];

  // Side-band pipeline that follows the pixel through the ROM lookups
  logic [2:0]  rx_lo_d1;
  logic [2:0]  rx_lo_d2;
  logic [2:0]  rx_lo_d3;
  logic [3:0]  ry_lo_d1;
  logic [3:0]  ry_lo_d2;
  logic        in_box_d1;
  logic        in_box_d2;
  logic        in_box_d3;
  logic        hl_d1;
  logic        hl_d2;
  logic        hl_d3;

  // Stage-3 compositing signals
  logic        pix;
  logic        blank_d3;
  logic [11:0] fg_col;
  logic [11:0] bg_col;
  logic [11:0] rgb_next;

  // Bits of the wide relative coordinates and the last delay stage colour are not needed
  logic        unused_bits;

  // Bundle the incoming beam sample so the delay line moves it as one word.
  always_comb begin
    beam_in        = BEAM_ZERO;
    beam_in.vcount = vcount_in;
    beam_in.hcount = hcount_in;
    beam_in.vsync  = vsync_in;
    beam_in.hsync  = hsync_in;
    beam_in.vblnk  = vblnk_in;
    beam_in.hblnk  = hblnk_in;
    beam_in.rgb    = rgb_in;
  end

  // Stage 0: box-relative position, box membership and the text-ROM index.
  always_comb begin
    rx           = hcount_in - XPOS;
    ry           = vcount_in - YPOS;
    h_ext        = {1'b0, hcount_in};
    v_ext        = {1'b0, vcount_in};
    xpos_ext     = {1'b0, XPOS};
    ypos_ext     = {1'b0, YPOS};
    in_box       = (h_ext >= xpos_ext) && (h_ext < (xpos_ext + BOX_W)) &&
                   (v_ext >= ypos_ext) && (v_ext < (ypos_ext + BOX_H));
    char_xy_next = {2'b00, ry[5:4], rx[6:3]};
    frame_start  = (vcount_in == 11'd0) && (hcount_in == 11'd0);
  end

  // Stage 0: a row is highlighted when enabled and its index matches the frame's selection.
  always_comb begin
    if (sel_en_lat && (ry[5:4] == sel_row_lat)) begin
      hl = 1'b1;
    end else begin
      hl = 1'b0;
    end
  end

  // Sample the highlight selection once per frame at beam position (0,0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_row_lat <= 2'b00;
      sel_en_lat  <= 1'b0;
    end else if (frame_start) begin
      sel_row_lat <= sel_row;
      sel_en_lat  <= sel_en;
    end else begin
      sel_row_lat <= sel_row_lat;
      sel_en_lat  <= sel_en_lat;
    end
  end

  // Text-ROM index; held outside the box because the ROM answer is discarded there anyway.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      char_xy <= 8'h00;
    end else if (in_box) begin
      char_xy <= char_xy_next;
    end else begin
      char_xy <= char_xy;
    end
  end

  // Fixed 4-clock delay line for counts, syncs, blanks and upstream colour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        beam_d[i] <= BEAM_ZERO;
      end
    end else begin
      beam_d[0] <= beam_in;
      for (int i = 1; i < DEPTH; i++) begin
        beam_d[i] <= beam_d[i-1];
      end
    end
  end

  // Side-band delay: glyph column/line, box flag and highlight flag follow the ROM latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_lo_d1  <= 3'd0;
      rx_lo_d2  <= 3'd0;
      rx_lo_d3  <= 3'd0;
      ry_lo_d1  <= 4'd0;
      ry_lo_d2  <= 4'd0;
      in_box_d1 <= 1'b0;
      in_box_d2 <= 1'b0;
      in_box_d3 <= 1'b0;
      hl_d1     <= 1'b0;
      hl_d2     <= 1'b0;
      hl_d3     <= 1'b0;
    end else begin
      rx_lo_d1  <= rx[2:0];
      rx_lo_d2  <= rx_lo_d1;
      rx_lo_d3  <= rx_lo_d2;
      ry_lo_d1  <= ry[3:0];
      ry_lo_d2  <= ry_lo_d1;
      in_box_d1 <= in_box;
      in_box_d2 <= in_box_d1;
      in_box_d3 <= in_box_d2;
      hl_d1     <= hl;
      hl_d2     <= hl_d1;
      hl_d3     <= hl_d2;
    end
  end

  // Font ROM address is formed directly from the text-ROM data, no extra register.
  assign font_addr = {char_code, ry_lo_d2};

  // Stage 3: pick the glyph pixel (MSB is leftmost) and swap colours on the highlighted row.
  always_comb begin
    pix      = char_pixels[3'd7 - rx_lo_d3];
    blank_d3 = beam_d[2].vblnk | beam_d[2].hblnk;
    if (hl_d3) begin
      fg_col = BG_RGB;
      bg_col = FG_RGB;
    end else begin
      fg_col = FG_RGB;
      bg_col = BG_RGB;
    end
  end

  // Stage 3: blanking forces black, outside the box the upstream colour passes through.
  always_comb begin
    if (blank_d3) begin
      rgb_next = 12'h000;
    end else if (!in_box_d3) begin
      rgb_next = beam_d[2].rgb;
    end else if (pix) begin
      rgb_next = fg_col;
    end else begin
      rgb_next = bg_col;
    end
  end

  // Composited colour register, aligned with the last delay-line stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_out <= 12'h000;
    end else begin
      rgb_out <= rgb_next;
    end
  end

  assign vcount_out = beam_d[DEPTH-1].vcount;
  assign hcount_out = beam_d[DEPTH-1].hcount;
  assign vsync_out  = beam_d[DEPTH-1].vsync;
  assign hsync_out  = beam_d[DEPTH-1].hsync;
  assign vblnk_out  = beam_d[DEPTH-1].vblnk;
  assign hblnk_out  = beam_d[DEPTH-1].hblnk;

  assign unused_bits = &{1'b0, rx[10:7], ry[10:6], beam_d[DEPTH-1].rgb};

endmodule

// File: doc/game_text_render.md
Name: game_text_render

Overview:
- Pixel-side consumer of the game text-content ROMs. Converts VGA beam position into a character index `char_xy`, accepts the returned `char_code` one cycle later, and fetches the glyph row from the font ROM.
- Overlays a 16-column x 4-row text box, with 8x16 px glyphs, onto the incoming VGA stream.
- Sits in the VGA chain between the background/game drawing stages and the output register.
- Renders one selectable row in inverse video, used for menu highlighting.

Parameters:
- XPOS, 11'd400, left pixel of text box
- YPOS, 11'd300, top pixel of text box
- FG_RGB, 12'hFFF, glyph colour
- BG_RGB, 12'h000, box background colour

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous active-high reset
- vcount_in  in  11  vertical beam position
- hcount_in  in  11  horizontal beam position
- vsync_in  in  1  vertical sync
- hsync_in  in  1  horizontal sync
- vblnk_in  in  1  vertical blanking
- hblnk_in  in  1  horizontal blanking
- rgb_in  in  12  upstream pixel colour
- sel_row  in  2  row index to render inverted
- sel_en  in  1  highlight enable
- char_xy  out  8  {row[3:0], col[3:0]} index to text-content ROM
- char_code  in  7  ROM data; valid 1 cycle after char_xy
- font_addr  out  11  {char_code, glyph_line[3:0]} to font ROM (combinational)
- char_pixels  in  8  font ROM data, registered in ROM; MSB = leftmost pixel
- vcount_out, hcount_out  out  11  delayed positions
- vsync_out, hsync_out, vblnk_out, hblnk_out  out  1  delayed timing signals
- rgb_out  out  12  composited colour

Behaviour:
- Reset (async, rst=1): every registered output and all pipeline stages go to 0, including char_xy, rgb_out and the latched select.
- Relative position, computed at stage 0: rx = hcount_in - XPOS, ry = vcount_in - YPOS, both 11-bit unsigned.
- in_box = (hcount_in >= XPOS) && (hcount_in < XPOS+128) && (vcount_in >= YPOS) && (vcount_in < YPOS+64). Compare at 12 bits so that XPOS+128 cannot wrap.
- char_xy is registered (T+1): {2'b00, ry[5:4], rx[6:3]}. Row field bits [3:2] are always 0.
- Outside the box, char_xy holds its previous value. The ROM result is ignored via the delayed in_box flag.
- char_code arrives at T+2. font_addr = {char_code, ry_d2[3:0]}, combinational. Only the ry/rx delay registers feed it; char_code itself is not re-registered.
- char_pixels arrives at T+3 (ROM registers).
- Bit select at T+3: pix = char_pixels[7 - rx_d3[2:0]].
- rgb_out registered at T+4:
  - if blanking_d3 (vblnk_d3 | hblnk_d3): 12'h000
  - else if !in_box_d3: rgb_d3
  - else: colour = pix ? FG_RGB : BG_RGB; if hl_d3, swap FG_RGB and BG_RGB.
- hl = sel_en_lat && (ry[5:4] == sel_row_lat), computed at stage 0 and delayed with the data.
- sel_row/sel_en latch: sampled into sel_row_lat/sel_en_lat only when vcount_in==0 && hcount_in==0. Mid-frame changes take effect the next frame, so a frame never tears.
- Latency: all *_out signals equal their *_in values delayed exactly 4 clocks. A 4-stage shift register carries rgb, counts, syncs and blanks.
- Pipeline throughput: one pixel per clock, no stalls, no handshake. The external ROMs must have fixed 1-cycle latency.
- Boundary cases:
  - First box pixel (rx=0) selects bit 7.
  - Last box pixel (rx=127) selects col 15, bit 0.
  - The pixel at hcount=XPOS+128 is passthrough.
- Reset mid-frame: pipeline clears. Up to 4 output pixels are black with syncs 0, then normal flow resumes without resynchronisation logic.

Test Plan:
- Reset then free-running 800x600 timing, sel_en=0 -> *_out equals *_in delayed 4 clocks; rgb_out=rgb_in outside the box and 0 during blanking.
- Beam at (XPOS+37, YPOS+21) -> char_xy=8'h14 one clock later. With font stub returning 8'b1010_0000 and rx[2:0]=5, bit 2=0 -> rgb_out=BG_RGB at T+4.
- Beam at (XPOS+0, YPOS+0), char_pixels=8'h80 -> rgb_out=FG_RGB. Pixel at XPOS+128 -> rgb_in passthrough. Pixel at YPOS+64 -> passthrough.
- sel_en=1, sel_row=2 set before frame start, beam in ry=32..47 -> FG and BG swapped. Other rows normal. Change sel_row mid-frame -> no effect until next frame's (0,0).
- Check font_addr: char_code stub=7'h41 at ry[3:0]=9 -> font_addr=11'h419 in the same cycle as char_code is presented.
- Assert rst for 3 clocks mid-line -> all outputs 0 immediately (async). After release, correct output resumes on the 5th clock.
